multicycle_main_fsm: RTL and testbench
======================================

Name: multicycle_main_fsm

Overview:
Main control FSM for the kianv multicycle RV32I core. It sequences the shared datapath (PC/OldPC/IR/ALUOut/Data registers, mux2/mux3/mux4 selects, register file) one state per cycle. It drives a single valid/ready memory port used for both instruction fetch and data access. ALU funct decoding, immediate generation and branch-condition evaluation sit outside this block.

Parameters:
- RESET_STATE, 0, state entered on reset (FETCH).
- TRAP_STICKY, 1: 1 = TRAP holds until reset; 0 = TRAP returns to FETCH after one cycle.

Ports:
- clk  in  1  clock
- resetn  in  1  reset
- opcode  in  7  IR[6:0], stable from DECODE onward
- branch_taken  in  1  branch condition from datapath compare, valid in BRANCH
- mem_ready  in  1  memory completes the access this cycle
- mem_valid  out  1  memory request
- mem_write  out  1  request is a store
- adr_src  out  1  0 = PC, 1 = ALUOut
- ir_write  out  1  IR/OldPC load enable
- pc_write  out  1  PC load enable
- reg_write  out  1  register file write enable
- alu_src_a  out  2  00 = PC, 01 = OldPC, 10 = rs1 register
- alu_src_b  out  2  00 = rs2 register, 01 = ImmExt, 10 = constant 4
- alu_op  out  2  00 = add, 01 = sub/compare, 10 = funct-decoded
- result_src  out  2  00 = ALUOut, 01 = Data, 10 = ALUResult, 11 = ImmExt
- retire  out  1  one-cycle pulse, instruction complete
- illegal  out  1  unsupported opcode seen
- state  out  4  current state (debug)

Behaviour:
- Reset: clk is the clock; resetn is synchronous, active-low. While resetn = 0, all strobes (mem_valid, mem_write, ir_write, pc_write, reg_write, retire) and illegal are 0, all selects are 0, and state is forced to RESET_STATE. The first FETCH request appears the cycle after resetn rises.
- State encoding: FETCH 0, DECODE 1, MEMADR 2, MEMREAD 3, MEMWB 4, MEMWRITE 5, EXECR 6, EXECI 7, ALUWB 8, BRANCH 9, JAL 10, JALR 11, LUI 12, TRAP 15. Codes 13 and 14 go to TRAP.
- Output defaults: all outputs are 0 unless listed for the current state.
- FETCH: mem_valid = 1, adr_src = 0, alu_src_a = 00, alu_src_b = 10, result_src = 10.
  - ir_write and pc_write equal mem_ready (Mealy).
  - The FSM stays in FETCH until mem_ready = 1, then moves to DECODE.
- DECODE: alu_src_a = 01, alu_src_b = 01, alu_op = 00, so ALUOut = OldPC + imm. Next state by opcode:
  - 0000011 / 0100011 → MEMADR
  - 0110011 → EXECR
  - 0010011 → EXECI
  - 1100011 → BRANCH
  - 1101111 → JAL
  - 1100111 → JALR
  - 0110111 → LUI
  - 0010111 → ALUWB (AUIPC)
  - any other opcode → TRAP
- MEMADR: alu_src_a = 10, alu_src_b = 01, alu_op = 00. Next state is MEMREAD if opcode[5] = 0, else MEMWRITE.
- MEMREAD: mem_valid = 1, adr_src = 1. Waits for mem_ready, then goes to MEMWB.
- MEMWB: result_src = 01, reg_write = 1, retire = 1. Next state FETCH.
- MEMWRITE: mem_valid = 1, mem_write = 1, adr_src = 1, all held stable until mem_ready.
  - On mem_ready: retire = 1 and next state is FETCH.
- EXECR: alu_src_a = 10, alu_src_b = 00, alu_op = 10. Next state ALUWB.
- EXECI: alu_src_a = 10, alu_src_b = 01, alu_op = 10. Next state ALUWB.
- ALUWB: result_src = 00, reg_write = 1, retire = 1. Next state FETCH.
- BRANCH: alu_src_a = 10, alu_src_b = 00, alu_op = 01, result_src = 00.
  - pc_write = branch_taken.
  - retire = 1; next state FETCH.
- JAL: alu_src_a = 01, alu_src_b = 10, alu_op = 00, result_src = 00, pc_write = 1. Next state ALUWB, which writes the link value OldPC + 4.
- JALR: alu_src_a = 10, alu_src_b = 01, alu_op = 00, so ALUOut = rs1 + imm. Next state JAL.
  - Target LSB clearing is done in the datapath, not here.
- LUI: result_src = 11, reg_write = 1, retire = 1. Next state FETCH.
- TRAP: illegal = 1 (registered, sticky until reset when TRAP_STICKY = 1). No memory requests. With TRAP_STICKY = 0, next state is FETCH.
- Memory handshake:
  - mem_ready is ignored when mem_valid = 0.
  - mem_valid, once asserted, stays high with stable adr_src and mem_write until mem_ready.
  - Wait-state count is unbounded.
- Latency with zero-wait memory, FETCH through retire:
  - LUI, AUIPC, BRANCH: 3 cycles
  - R-type, I-type, JAL, store: 4 cycles
  - load, JALR: 5 cycles
  - Each memory wait cycle adds 1.
- Reset mid-operation: an outstanding request is dropped; mem_valid is 0 the next cycle, with no write strobe leakage.

Test Plan:
- Reset release; mem_ready low for 2 cycles, then high → mem_valid high for 3 cycles; ir_write = pc_write = 1 only in the third; state 0→0→0→1.
- opcode 0110011, zero-wait memory → state sequence 0,1,6,8,0; reg_write and retire only in the ALUWB cycle; alu_op = 10 in EXECR.
- opcode 0000011, mem_ready delayed 3 cycles in MEMREAD → adr_src = 1 held throughout; state 2,3,3,3,3,4; reg_write with result_src = 01 once.
- opcode 1100011 with branch_taken = 1, then = 0 → pc_write = 1, then 0, in the BRANCH cycle; both paths retire after 3 cycles.
- opcode 1100111 → states 1,11,10,8,0; pc_write only in JAL; reg_write only in ALUWB.
- opcode 1111111 → TRAP, illegal = 1, mem_valid stays 0 for 20 cycles. Separately, resetn = 0 during MEMWRITE wait → mem_write = 0 next cycle; state 0 after release.

Source files
------------

// File: rtl/multicycle_main_fsm.sv
// Main control FSM for the multicycle RV32I core: one state per cycle, shared
// valid/ready memory port for instruction fetch and data access.
module multicycle_main_fsm #(
  parameter logic [3:0] RESET_STATE = 4'd0,
  parameter bit         TRAP_STICKY = 1'b1
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic [6:0] opcode,
  input  logic       branch_taken,
  input  logic       mem_ready,
  output logic       mem_valid,
  output logic       mem_write,
  output logic       adr_src,
  output logic       ir_write,
  output logic       pc_write,
  output logic       reg_write,
  output logic [1:0] alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] alu_op,
  output logic [1:0] result_src,
  output logic       retire,
  output logic       illegal,
  output logic [3:0] state
);

  localparam logic [3:0] StFetch    = 4'd0;
  localparam logic [3:0] StDecode   = 4'd1;
  localparam logic [3:0] StMemAdr   = 4'd2;
  localparam logic [3:0] StMemRead  = 4'd3;
  localparam logic [3:0] StMemWb    = 4'd4;
  localparam logic [3:0] StMemWrite = 4'd5;
  localparam logic [3:0] StExecR    = 4'd6;
  localparam logic [3:0] StExecI    = 4'd7;
  localparam logic [3:0] StAluWb    = 4'd8;
  localparam logic [3:0] StBranch   = 4'd9;
  localparam logic [3:0] StJal      = 4'd10;
  localparam logic [3:0] StJalr     = 4'd11;
  localparam logic [3:0] StLui      = 4'd12;
  localparam logic [3:0] StTrap     = 4'd15;

  localparam logic [6:0] OpLoad   = 7'b0000011;
  localparam logic [6:0] OpStore  = 7'b0100011;
  localparam logic [6:0] OpR      = 7'b0110011;
  localparam logic [6:0] OpI      = 7'b0010011;
  localparam logic [6:0] OpBranch = 7'b1100011;
  localparam logic [6:0] OpJal    = 7'b1101111;
  localparam logic [6:0] OpJalr   = 7'b1100111;
  localparam logic [6:0] OpLui    = 7'b0110111;
  localparam logic [6:0] OpAuipc  = 7'b0010111;

  logic [3:0] state_q, state_d;

  always_comb begin
    state_d = state_q;
    case (state_q)
      StFetch:    if (mem_ready) state_d = StDecode;
      StDecode: begin
        case (opcode)
          OpLoad, OpStore: state_d = StMemAdr;
          OpR:             state_d = StExecR;
          OpI:             state_d = StExecI;
          OpBranch:        state_d = StBranch;
          OpJal:           state_d = StJal;
          OpJalr:          state_d = StJalr;
          OpLui:           state_d = StLui;
          OpAuipc:         state_d = StAluWb;
          default:         state_d = StTrap;
        endcase
      end
      StMemAdr:   state_d = opcode[5] ? StMemWrite : StMemRead;
      StMemRead:  if (mem_ready) state_d = StMemWb;
      StMemWb:    state_d = StFetch;
      StMemWrite: if (mem_ready) state_d = StFetch;
      StExecR:    state_d = StAluWb;
      StExecI:    state_d = StAluWb;
      StAluWb:    state_d = StFetch;
      StBranch:   state_d = StFetch;
      // JAL also serves as the second half of JALR: PC <= ALUOut, link computed
      StJal:      state_d = StAluWb;
      StJalr:     state_d = StJal;
      StLui:      state_d = StFetch;
      StTrap:     state_d = TRAP_STICKY ? StTrap : StFetch;
      default:    state_d = StTrap;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q <= RESET_STATE;
    end else begin
      state_q <= state_d;
    end
  end

  // Outputs are forced quiet for as long as resetn is low, so a request that
  // is in flight when reset hits is dropped immediately.
  always_comb begin
    mem_valid  = 1'b0;
    mem_write  = 1'b0;
    adr_src    = 1'b0;
    ir_write   = 1'b0;
    pc_write   = 1'b0;
    reg_write  = 1'b0;
    alu_src_a  = 2'b00;
    alu_src_b  = 2'b00;
    alu_op     = 2'b00;
    result_src = 2'b00;
    retire     = 1'b0;
    illegal    = 1'b0;
    if (resetn) begin
      case (state_q)
        StFetch: begin
          mem_valid  = 1'b1;
          alu_src_b  = 2'b10;
          result_src = 2'b10;
          ir_write   = mem_ready;
          pc_write   = mem_ready;
        end
        StDecode: begin
          alu_src_a = 2'b01;
          alu_src_b = 2'b01;
        end
        StMemAdr: begin
          alu_src_a = 2'b10;
          alu_src_b = 2'b01;
        end
        StMemRead: begin
          mem_valid = 1'b1;
          adr_src   = 1'b1;
        end
        StMemWb: begin
          result_src = 2'b01;
          reg_write  = 1'b1;
          retire     = 1'b1;
        end
        StMemWrite: begin
          mem_valid = 1'b1;
          mem_write = 1'b1;
          adr_src   = 1'b1;
          retire    = mem_ready;
        end
        StExecR: begin
          alu_src_a = 2'b10;
          alu_op    = 2'b10;
        end
        StExecI: begin
          alu_src_a = 2'b10;
          alu_src_b = 2'b01;
          alu_op    = 2'b10;
        end
        StAluWb: begin
          reg_write = 1'b1;
          retire    = 1'b1;
        end
        StBranch: begin
          alu_src_a = 2'b10;
          alu_op    = 2'b01;
          pc_write  = branch_taken;
          retire    = 1'b1;
        end
        StJal: begin
          alu_src_a = 2'b01;
          alu_src_b = 2'b10;
          pc_write  = 1'b1;
        end
        StJalr: begin
          alu_src_a = 2'b10;
          alu_src_b = 2'b01;
        end
        StLui: begin
          result_src = 2'b11;
          reg_write  = 1'b1;
          retire     = 1'b1;
        end
        StTrap:  illegal = 1'b1;
        default: ;
      endcase
    end
  end

  assign state = state_q;

endmodule

// File: tb/tb_multicycle_main_fsm.sv
// Bench for multicycle_main_fsm: zero-wait vector table, hand-written corner
// sequences, and random instruction streams against a latency/strobe model.
module tb_multicycle_main_fsm;

  logic       clk = 1'b0;
  logic       resetn;
  logic [6:0] opcode;
  logic       branch_taken;
  logic       mem_ready;
  logic       mem_valid, mem_write, adr_src, ir_write, pc_write, reg_write;
  logic [1:0] alu_src_a, alu_src_b, alu_op, result_src;
  logic       retire, illegal;
  logic [3:0] state;

  multicycle_main_fsm dut (
    .clk          (clk),
    .resetn       (resetn),
    .opcode       (opcode),
    .branch_taken (branch_taken),
    .mem_ready    (mem_ready),
    .mem_valid    (mem_valid),
    .mem_write    (mem_write),
    .adr_src      (adr_src),
    .ir_write     (ir_write),
    .pc_write     (pc_write),
    .reg_write    (reg_write),
    .alu_src_a    (alu_src_a),
    .alu_src_b    (alu_src_b),
    .alu_op       (alu_op),
    .result_src   (result_src),
    .retire       (retire),
    .illegal      (illegal),
    .state        (state)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic do_reset();
    resetn       = 1'b0;
    mem_ready    = 1'b0;
    opcode       = 7'd0;
    branch_taken = 1'b0;
    nxt();
    nxt();
    settle();
    chk("rst_state", state, 0);
    chk("rst_strobes", {mem_valid, mem_write, ir_write, pc_write, reg_write, retire, illegal}, 0);
    chk("rst_selects", {adr_src, alu_src_a, alu_src_b, alu_op, result_src}, 0);
    resetn = 1'b1;
  endtask

  typedef struct {
    logic [6:0]  op;
    logic        bt;
    int          n;
    logic [23:0] st;   // nibble c = expected state in cycle c
    logic [5:0]  regw;
    logic [5:0]  pcw;
    logic [5:0]  ret;
  } vec_t;

  function automatic vec_t mk(input logic [6:0] op, input logic bt, input int n,
                              input logic [23:0] st, input logic [5:0] regw,
                              input logic [5:0] pcw, input logic [5:0] ret);
    vec_t v;
    v.op = op; v.bt = bt; v.n = n; v.st = st; v.regw = regw; v.pcw = pcw; v.ret = ret;
    return v;
  endfunction

  function automatic int base_lat(input logic [6:0] op);
    case (op)
      7'b0110111, 7'b0010111, 7'b1100011: return 3;
      7'b0000011, 7'b1100111:             return 5;
      default:                            return 4;
    endcase
  endfunction

  vec_t       vecs[10];
  logic [6:0] legal_ops[9];

  initial begin
    logic [23:0] stv;
    vecs[0] = mk(7'b0110011, 1'b0, 4, 24'h008610, 6'b001000, 6'b000001, 6'b001000);
    vecs[1] = mk(7'b0010011, 1'b0, 4, 24'h008710, 6'b001000, 6'b000001, 6'b001000);
    vecs[2] = mk(7'b0000011, 1'b0, 5, 24'h043210, 6'b010000, 6'b000001, 6'b010000);
    vecs[3] = mk(7'b0100011, 1'b0, 4, 24'h005210, 6'b000000, 6'b000001, 6'b001000);
    vecs[4] = mk(7'b1100011, 1'b1, 3, 24'h000910, 6'b000000, 6'b000101, 6'b000100);
    vecs[5] = mk(7'b1100011, 1'b0, 3, 24'h000910, 6'b000000, 6'b000001, 6'b000100);
    vecs[6] = mk(7'b1101111, 1'b0, 4, 24'h008A10, 6'b001000, 6'b000101, 6'b001000);
    vecs[7] = mk(7'b1100111, 1'b0, 5, 24'h08AB10, 6'b010000, 6'b001001, 6'b010000);
    vecs[8] = mk(7'b0110111, 1'b0, 3, 24'h000C10, 6'b000100, 6'b000001, 6'b000100);
    vecs[9] = mk(7'b0010111, 1'b0, 3, 24'h000810, 6'b000100, 6'b000001, 6'b000100);
    for (int i = 0; i < 9; i++) legal_ops[i] = (i < 4) ? vecs[i].op : vecs[i + 1].op;

    // Zero-wait table
    for (int e = 0; e < 10; e++) begin
      do_reset();
      opcode       = vecs[e].op;
      branch_taken = vecs[e].bt;
      mem_ready    = 1'b1;
      stv          = vecs[e].st;
      for (int c = 0; c < vecs[e].n; c++) begin
        settle();
        chk($sformatf("v%0d_c%0d_state", e, c), state, stv[c*4 +: 4]);
        chk($sformatf("v%0d_c%0d_regw", e, c), reg_write, vecs[e].regw[c]);
        chk($sformatf("v%0d_c%0d_pcw", e, c), pc_write, vecs[e].pcw[c]);
        chk($sformatf("v%0d_c%0d_ret", e, c), retire, vecs[e].ret[c]);
        if (stv[c*4 +: 4] == 4'd6) chk($sformatf("v%0d_execr_aluop", e), alu_op, 2);
        nxt();
      end
      settle();
      chk($sformatf("v%0d_back_fetch", e), state, 0);
    end

    // Fetch with two wait cycles right after reset release
    do_reset();
    for (int i = 0; i < 3; i++) begin
      mem_ready = (i == 2);
      settle();
      chk($sformatf("fw%0d_valid", i), mem_valid, 1);
      chk($sformatf("fw%0d_irw", i), ir_write, (i == 2));
      chk($sformatf("fw%0d_pcw", i), pc_write, (i == 2));
      chk($sformatf("fw%0d_state", i), state, 0);
      nxt();
    end
    settle();
    chk("fw_decode", state, 1);

    // Load with three wait states in MEMREAD
    do_reset();
    opcode    = 7'b0000011;
    mem_ready = 1'b1;
    nxt();
    nxt();
    mem_ready = 1'b0;
    settle();
    chk("ld_memadr", state, 2);
    nxt();
    for (int i = 0; i < 4; i++) begin
      mem_ready = (i == 3);
      settle();
      chk($sformatf("ld_rd%0d_state", i), state, 3);
      chk($sformatf("ld_rd%0d_adr", i), {mem_valid, adr_src, reg_write}, 3'b110);
      nxt();
    end
    settle();
    chk("ld_wb_state", state, 4);
    chk("ld_wb_strobe", {reg_write, result_src, retire}, 4'b1011);
    nxt();
    settle();
    chk("ld_fetch", state, 0);

    // Illegal opcode traps and stays quiet
    do_reset();
    opcode    = 7'b1111111;
    mem_ready = 1'b1;
    nxt();
    nxt();
    for (int i = 0; i < 20; i++) begin
      mem_ready = 1'($urandom);
      settle();
      chk($sformatf("trap%0d", i), {state, illegal, mem_valid, retire}, {4'd15, 3'b100});
      nxt();
    end

    // Reset during a stalled store
    do_reset();
    opcode    = 7'b0100011;
    mem_ready = 1'b1;
    nxt();
    nxt();
    mem_ready = 1'b0;
    nxt();
    settle();
    chk("st_wait_state", state, 5);
    chk("st_wait_mw", {mem_valid, mem_write, adr_src}, 3'b111);
    nxt();
    settle();
    chk("st_hold_mw", {mem_valid, mem_write, adr_src}, 3'b111);
    resetn = 1'b0;
    settle();
    chk("st_rst_gate", {mem_valid, mem_write, retire}, 0);
    nxt();
    settle();
    chk("st_rst_next", {state, mem_valid, mem_write}, 0);
    resetn = 1'b1;
    settle();
    chk("st_release_state", state, 0);
    chk("st_release_fetch", mem_valid, 1);

    // Random instruction streams with random memory stalls
    do_reset();
    begin
      logic pend, p_adr, p_mw;
      pend = 1'b0; p_adr = 1'b0; p_mw = 1'b0;
      for (int k = 0; k < 200; k++) begin
        logic [6:0] op;
        logic       bt, done, mw;
        int         cyc, waits, rw, pw, exp_pw;
        op    = legal_ops[$urandom_range(0, 8)];
        bt    = 1'($urandom);
        done  = 1'b0; mw = 1'b0;
        cyc   = 0; waits = 0; rw = 0; pw = 0;
        opcode       = op;
        branch_taken = bt;
        while (!done && cyc < 100) begin
          mem_ready = ($urandom_range(0, 3) != 0);
          settle();
          if (pend) chk($sformatf("r%0d_hs", k), {mem_valid, adr_src, mem_write},
                        {1'b1, p_adr, p_mw});
          cyc++;
          if (mem_valid && !mem_ready) waits++;
          rw += int'(reg_write);
          pw += int'(pc_write);
          if (mem_write) mw = 1'b1;
          if (retire) done = 1'b1;
          pend  = mem_valid && !mem_ready;
          p_adr = adr_src;
          p_mw  = mem_write;
          nxt();
        end
        exp_pw = 1 + ((op == 7'b1101111 || op == 7'b1100111) ? 1 : 0)
                   + ((op == 7'b1100011 && bt) ? 1 : 0);
        chk($sformatf("r%0d_retired", k), done, 1);
        chk($sformatf("r%0d_lat op=%b", k, op), cyc, base_lat(op) + waits);
        chk($sformatf("r%0d_regw", k), rw, (op == 7'b0100011 || op == 7'b1100011) ? 0 : 1);
        chk($sformatf("r%0d_pcw", k), pw, exp_pw);
        chk($sformatf("r%0d_memw", k), mw, (op == 7'b0100011));
        if (!done) break;
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
